// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter onto a single data-memory port
//
// Shares one memory port between port 0 (CPU load/store) and port 1 (second
// bus master). Each port runs a req/ack handshake. The winning transaction
// is latched and then replayed onto the memory port. Every output comes from
// a flop, so there is no combinational path from any input to any output.
//
// Parameters:
//   AW      address width
//   DW      data width
//   RD_LAT  memory read latency in cycles (1..3)
//
// Ports:
//   i_clk, i_reset                 clock, asynchronous active-low reset
//   i_mN_req/wr/addr/wdata         port N request, direction, address, write data
//   o_mN_ack, o_mN_rdata           port N completion pulse, read data
//   o_mem_rd/wr/addr/wdata         memory strobes, address and write data
//   i_mem_rdata                    memory read data
//   o_gnt                          one-hot owner (00 when idle)
//   o_busy                         high whenever the FSM is not in IDLE
module mem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_m0_req,
  input  logic          i_m0_wr,
  input  logic [AW-1:0] i_m0_addr,
  input  logic [DW-1:0] i_m0_wdata,
  output logic          o_m0_ack,
  output logic [DW-1:0] o_m0_rdata,
  input  logic          i_m1_req,
  input  logic          i_m1_wr,
  input  logic [AW-1:0] i_m1_addr,
  input  logic [DW-1:0] i_m1_wdata,
  output logic          o_m1_ack,
  output logic [DW-1:0] o_m1_rdata,
  output logic          o_mem_rd,
  output logic          o_mem_wr,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic [1:0]    o_gnt,
  output logic          o_busy
);

  localparam int CW = 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_grant;
  logic            w_sel1;
  logic            w_sel_wr;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;

  logic            r_owner;
  logic            r_wr;
  logic            r_last;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_rdata0;
  logic [DW-1:0]   r_rdata1;
  logic [1:0]      r_gnt;
  logic            r_busy;
  logic            r_mem_rd;
  logic            r_mem_wr;
  logic            r_ack0;
  logic            r_ack1;

  // Next-state and arbitration decision
  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_sel1  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant = i_m0_req | i_m1_req;
        // On a tie, serve the port that was not served last
        if (i_m0_req && i_m1_req) w_sel1 = ~r_last;
        else                      w_sel1 = i_m1_req;
        if (w_grant) w_next = S_ACCESS;
      end
      S_ACCESS: w_next = r_wr ? S_DONE : S_WAIT;
      S_WAIT:   if (r_cnt == '0) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_sel_wr    = w_sel1 ? i_m1_wr    : i_m0_wr;
  assign w_sel_addr  = w_sel1 ? i_m1_addr  : i_m0_addr;
  assign w_sel_wdata = w_sel1 ? i_m1_wdata : i_m0_wdata;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_wr     <= 1'b0;
      r_last   <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_gnt    <= 2'b00;
      r_busy   <= 1'b0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);

      // Strobes are registered from the grant decision so they are high
      // exactly in the ACCESS cycle and come straight off a flop
      r_mem_rd <= w_grant & ~w_sel_wr;
      r_mem_wr <= w_grant &  w_sel_wr;

      // Ack flops are set on the way into DONE so the pulse lines up with it
      r_ack0 <= (w_next == S_DONE) && !r_owner;
      r_ack1 <= (w_next == S_DONE) &&  r_owner;

      if (w_grant) begin
        r_owner <= w_sel1;
        r_wr    <= w_sel_wr;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
        r_gnt   <= w_sel1 ? 2'b10 : 2'b01;
      end

      if (r_state == S_DONE) begin
        r_gnt  <= 2'b00;
        r_last <= r_owner;
      end

      if (r_state == S_ACCESS && !r_wr)
        r_cnt <= CW'(RD_LAT - 1);
      else if (r_state == S_WAIT && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;

      if (r_state == S_WAIT && r_cnt == '0) begin
        if (r_owner) r_rdata1 <= i_mem_rdata;
        else         r_rdata0 <= i_mem_rdata;
      end
    end
  end

  assign o_m0_ack    = r_ack0;
  assign o_m1_ack    = r_ack1;
  assign o_m0_rdata  = r_rdata0;
  assign o_m1_rdata  = r_rdata1;
  assign o_mem_rd    = r_mem_rd;
  assign o_mem_wr    = r_mem_wr;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_gnt       = r_gnt;
  assign o_busy      = r_busy;

endmodule
